// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with HUNT/RUN frame alignment.
// Define DEMUX_FRAME_BUF_EN to publish whole frames at once through a shadow buffer.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] ch_out,
    output logic [3:0]         ch_valid,
    output logic               frame_done,
    output logic [1:0]         slot,
    output logic               sync_err
);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [1:0]         slot_q, slot_d;
    logic [4*WIDTH-1:0] ch_q, ch_d;
    logic [3:0]         ch_valid_q, ch_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               sync_err_q, sync_err_d;
    logic               cap;
    logic [1:0]         cap_slot;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cap        = 1'b0;
        cap_slot   = slot_q;
        sync_err_d = 1'b0;
        if (din_valid) begin
            if (state_q == ST_HUNT) begin
                if (frame_sync) begin
                    cap      = 1'b1;
                    cap_slot = 2'd0;
                    state_d  = ST_RUN;
                end
            end else begin
                cap = 1'b1;
                // A sync always realigns to slot 0; mid-frame it is an error.
                if (frame_sync) begin
                    cap_slot   = 2'd0;
                    sync_err_d = (slot_q != 2'd0);
                end
            end
            if (cap) begin
                slot_d = cap_slot + 2'd1;
            end
        end
    end

`ifdef DEMUX_FRAME_BUF_EN
    logic [3*WIDTH-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d     = shadow_q;
        ch_d         = ch_q;
        ch_valid_d   = 4'b0000;
        frame_done_d = 1'b0;
        if (sync_err_d) begin
            shadow_d = '0;
        end
        if (cap) begin
            if (cap_slot == 2'd3) begin
                ch_d         = {din, shadow_q};
                ch_valid_d   = 4'b1111;
                frame_done_d = 1'b1;
                shadow_d     = '0;
            end else begin
                shadow_d[cap_slot*WIDTH +: WIDTH] = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    always_comb begin
        ch_d         = ch_q;
        ch_valid_d   = 4'b0000;
        frame_done_d = 1'b0;
        if (cap) begin
            ch_d[cap_slot*WIDTH +: WIDTH] = din;
            ch_valid_d[cap_slot]          = 1'b1;
            frame_done_d                  = (cap_slot == 2'd3);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            slot_q       <= 2'd0;
            ch_q         <= '0;
            ch_valid_q   <= 4'b0000;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            ch_q         <= ch_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch_out     = ch_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign slot       = slot_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4; expectations follow DEMUX_FRAME_BUF_EN.
module tb_tdm_demux4;

`ifdef DEMUX_FRAME_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [31:0] ch_out;
    logic [3:0]  ch_valid;
    logic        frame_done;
    logic [1:0]  slot;
    logic        sync_err;

    int n_assert = 0;
    int n_fail   = 0;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_out     (ch_out),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .slot       (slot),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic s, input logic [7:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_ch,
                           input logic [3:0] e_cv, input logic e_fd,
                           input logic e_se, input logic [1:0] e_sl);
        chk({tag, ".ch_out"}, ch_out, e_ch);
        chk({tag, ".ch_valid"}, {28'd0, ch_valid}, {28'd0, e_cv});
        chk({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, e_fd});
        chk({tag, ".sync_err"}, {31'd0, sync_err}, {31'd0, e_se});
        chk({tag, ".slot"}, {30'd0, slot}, {30'd0, e_sl});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        chk_all("reset", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        // basic frame A1 B2 C3 D4
        step(1'b1, 1'b1, 8'hA1);
        chk_all("frm.a1", BUF ? 32'h0 : 32'h000000A1,
                BUF ? 4'b0000 : 4'b0001, 1'b0, 1'b0, 2'd1);
        step(1'b1, 1'b0, 8'hB2);
        chk_all("frm.b2", BUF ? 32'h0 : 32'h0000B2A1,
                BUF ? 4'b0000 : 4'b0010, 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b0, 8'hC3);
        chk_all("frm.c3", BUF ? 32'h0 : 32'h00C3B2A1,
                BUF ? 4'b0000 : 4'b0100, 1'b0, 1'b0, 2'd3);
        step(1'b1, 1'b0, 8'hD4);
        chk_all("frm.d4", 32'hD4C3B2A1,
                BUF ? 4'b1111 : 4'b1000, 1'b1, 1'b0, 2'd0);
        step(1'b0, 1'b0, 8'h00);
        chk_all("frm.idle", 32'hD4C3B2A1, 4'b0000, 1'b0, 1'b0, 2'd0);

        // free-running frame: slot 0 without sync
        step(1'b1, 1'b0, 8'hE5);
        chk_all("free.e5", BUF ? 32'hD4C3B2A1 : 32'hD4C3B2E5,
                BUF ? 4'b0000 : 4'b0001, 1'b0, 1'b0, 2'd1);

        // reset overrides valid+sync; then HUNT drops unsynced words
        rst = 1'b1;
        step(1'b1, 1'b1, 8'hEE);
        chk_all("rst.ovr", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h55);
        chk_all("hunt.55", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 8'h66);
        chk_all("hunt.66", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 8'h77);
        chk_all("hunt.77", BUF ? 32'h0 : 32'h00000077,
                BUF ? 4'b0000 : 4'b0001, 1'b0, 1'b0, 2'd1);

        // mid-frame sync error, then complete the realigned frame
        do_reset();
        step(1'b1, 1'b1, 8'h11);
        chk_all("serr.11", BUF ? 32'h0 : 32'h00000011,
                BUF ? 4'b0000 : 4'b0001, 1'b0, 1'b0, 2'd1);
        step(1'b1, 1'b0, 8'h22);
        chk_all("serr.22", BUF ? 32'h0 : 32'h00002211,
                BUF ? 4'b0000 : 4'b0010, 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b1, 8'h33);
        chk_all("serr.33", BUF ? 32'h0 : 32'h00002233,
                BUF ? 4'b0000 : 4'b0001, 1'b0, 1'b1, 2'd1);
        step(1'b1, 1'b0, 8'h66);
        chk_all("serr.66", BUF ? 32'h0 : 32'h00006633,
                BUF ? 4'b0000 : 4'b0010, 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b0, 8'h77);
        chk_all("serr.77", BUF ? 32'h0 : 32'h00776633,
                BUF ? 4'b0000 : 4'b0100, 1'b0, 1'b0, 2'd3);
        step(1'b1, 1'b0, 8'h88);
        chk_all("serr.88", 32'h88776633,
                BUF ? 4'b1111 : 4'b1000, 1'b1, 1'b0, 2'd0);

        // stall holds slot and suppresses pulses
        do_reset();
        step(1'b1, 1'b1, 8'h11);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'hFF);
            chk_all("stall", BUF ? 32'h0 : 32'h00000011,
                    4'b0000, 1'b0, 1'b0, 2'd1);
        end
        step(1'b1, 1'b0, 8'h22);
        chk_all("stall.22", BUF ? 32'h0 : 32'h00002211,
                BUF ? 4'b0000 : 4'b0010, 1'b0, 1'b0, 2'd2);

        // reset mid-frame discards partial data
        do_reset();
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        chk("mid.slot", {30'd0, slot}, 32'd3);
        rst = 1'b1;
        step(1'b1, 1'b1, 8'hFF);
        chk_all("mid.rst", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h99);
        chk_all("mid.hunt", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 8'hAA);
        step(1'b1, 1'b0, 8'hBB);
        step(1'b1, 1'b0, 8'hCC);
        step(1'b1, 1'b0, 8'hDD);
        chk_all("mid.frm", 32'hDDCCBBAA,
                BUF ? 4'b1111 : 4'b1000, 1'b1, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
